// File: rtl/sap1_pkg.sv
// sap1_pkg: opcodes, control-word layout and T-state encodings for the SAP-1 controller
package sap1_pkg;
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;
  localparam int CW_W        = 12;
  localparam int CW_PC_INC   = 11;
  localparam int CW_PC_EN    = 10;
  localparam int CW_MAR_LOAD = 9;
  localparam int CW_RAM_EN   = 8;
  localparam int CW_IR_LOAD  = 7;
  localparam int CW_IR_EN    = 6;
  localparam int CW_A_LOAD   = 5;
  localparam int CW_A_EN     = 4;
  localparam int CW_B_LOAD   = 3;
  localparam int CW_ALU_SUB  = 2;
  localparam int CW_ALU_EN   = 1;
  localparam int CW_OUT_LOAD = 0;
  localparam logic [CW_W-1:0] C_PC_INC   = CW_W'(1) << CW_PC_INC;
  localparam logic [CW_W-1:0] C_PC_EN    = CW_W'(1) << CW_PC_EN;
  localparam logic [CW_W-1:0] C_MAR_LOAD = CW_W'(1) << CW_MAR_LOAD;
  localparam logic [CW_W-1:0] C_RAM_EN   = CW_W'(1) << CW_RAM_EN;
  localparam logic [CW_W-1:0] C_IR_LOAD  = CW_W'(1) << CW_IR_LOAD;
  localparam logic [CW_W-1:0] C_IR_EN    = CW_W'(1) << CW_IR_EN;
  localparam logic [CW_W-1:0] C_A_LOAD   = CW_W'(1) << CW_A_LOAD;
  localparam logic [CW_W-1:0] C_A_EN     = CW_W'(1) << CW_A_EN;
  localparam logic [CW_W-1:0] C_B_LOAD   = CW_W'(1) << CW_B_LOAD;
  localparam logic [CW_W-1:0] C_ALU_SUB  = CW_W'(1) << CW_ALU_SUB;
  localparam logic [CW_W-1:0] C_ALU_EN   = CW_W'(1) << CW_ALU_EN;
  localparam logic [CW_W-1:0] C_OUT_LOAD = CW_W'(1) << CW_OUT_LOAD;
  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;
  function automatic logic is_arith(input logic [3:0] op);
    return op == OP_ADD || op == OP_SUB;
  endfunction
endpackage

// File: rtl/ring_counter.sv
// ring_counter: six-state one-hot T-state ring, holds while hold is high
module ring_counter
  import sap1_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  output logic [5:0] t
);
  always_ff @(posedge clk) begin
    if (rst) t <= T1;
    else if (!hold) t <= {t[4:0], t[5]};
  end
endmodule

// File: rtl/sap_controller.sv
// sap_controller: SAP-1 sequencer decoding the control word from T-state and opcode
module sap_controller
  import sap1_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  output logic [5:0] t_state,
  output logic       pc_inc,
  output logic       pc_en,
  output logic       mar_load,
  output logic       ram_en,
  output logic       ir_load,
  output logic       ir_en,
  output logic       a_load,
  output logic       a_en,
  output logic       b_load,
  output logic       alu_sub,
  output logic       alu_en,
  output logic       out_load,
  output logic       halt
);
  logic            hlt_t4;
  logic [CW_W-1:0] cw;
  assign hlt_t4 = t_state == T4 && opcode == OP_HLT;
  // the ring must not step past T4 on the very edge that sets halt
  ring_counter u_ring (
    .clk  (clk),
    .rst  (rst),
    .hold (halt | hlt_t4),
    .t    (t_state)
  );
  always_ff @(posedge clk) begin
    if (rst) halt <= 1'b0;
    else if (hlt_t4) halt <= 1'b1;
  end
  always_comb begin
    cw = '0;
    case (t_state)
      T1: cw = C_PC_EN | C_MAR_LOAD;
      T2: cw = C_PC_INC;
      T3: cw = C_RAM_EN | C_IR_LOAD;
      T4: cw = (opcode == OP_LDA || is_arith(opcode)) ? (C_IR_EN | C_MAR_LOAD) :
               opcode == OP_OUT ? (C_A_EN | C_OUT_LOAD) : '0;
      T5: cw = opcode == OP_LDA ? (C_RAM_EN | C_A_LOAD) :
               is_arith(opcode) ? (C_RAM_EN | C_B_LOAD) : '0;
      T6: cw = opcode == OP_ADD ? (C_ALU_EN | C_A_LOAD) :
               opcode == OP_SUB ? (C_ALU_EN | C_A_LOAD | C_ALU_SUB) : '0;
      default: cw = '0;
    endcase
    if (rst || halt) cw = '0;
  end
  assign pc_inc   = cw[CW_PC_INC];
  assign pc_en    = cw[CW_PC_EN];
  assign mar_load = cw[CW_MAR_LOAD];
  assign ram_en   = cw[CW_RAM_EN];
  assign ir_load  = cw[CW_IR_LOAD];
  assign ir_en    = cw[CW_IR_EN];
  assign a_load   = cw[CW_A_LOAD];
  assign a_en     = cw[CW_A_EN];
  assign b_load   = cw[CW_B_LOAD];
  assign alu_sub  = cw[CW_ALU_SUB];
  assign alu_en   = cw[CW_ALU_EN];
  assign out_load = cw[CW_OUT_LOAD];
endmodule

// File: tb/tb_sap_controller.sv
// tb_sap_controller: directed and random checks of the SAP-1 sequencer against a cycle model
module tb_sap_controller;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic [5:0] t_state;
  logic pc_inc, pc_en, mar_load, ram_en, ir_load, ir_en;
  logic a_load, a_en, b_load, alu_sub, alu_en, out_load, halt;
  logic [11:0] dut_cw;
  typedef struct {
    string       tag;
    bit          chk;
    logic [5:0]  t;
    logic        h;
    logic [11:0] cw;
  } sb_t;
  sb_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  int mt = 0;
  logic mh = 1'b0;
  always #5 clk = ~clk;
  sap_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .t_state(t_state),
    .pc_inc(pc_inc), .pc_en(pc_en), .mar_load(mar_load), .ram_en(ram_en),
    .ir_load(ir_load), .ir_en(ir_en), .a_load(a_load), .a_en(a_en),
    .b_load(b_load), .alu_sub(alu_sub), .alu_en(alu_en), .out_load(out_load),
    .halt(halt)
  );
  assign dut_cw = {pc_inc, pc_en, mar_load, ram_en, ir_load, ir_en,
                   a_load, a_en, b_load, alu_sub, alu_en, out_load};
  function automatic logic [11:0] model_cw(input int t, input logic [3:0] op);
    case (t)
      0: return 12'h600;
      1: return 12'h800;
      2: return 12'h180;
      3: return (op <= 4'h2) ? 12'h240 : (op == 4'hE) ? 12'h011 : 12'h000;
      4: return (op == 4'h0) ? 12'h120 : (op == 4'h1 || op == 4'h2) ? 12'h108 : 12'h000;
      5: return (op == 4'h1) ? 12'h022 : (op == 4'h2) ? 12'h026 : 12'h000;
      default: return 12'h000;
    endcase
  endfunction
  task automatic check();
    sb_t e;
    int  drv;
    e = sb.pop_front();
    drv = int'(pc_en) + int'(ram_en) + int'(ir_en) + int'(a_en) + int'(alu_en);
    n_cmp++;
    assert (dut_cw === e.cw) else begin
      n_err++;
      $error("FAIL %s cw got %03h exp %03h", e.tag, dut_cw, e.cw);
    end
    n_cmp++;
    assert (drv <= 1) else begin
      n_err++;
      $error("FAIL %s bus drivers got %0d exp <=1", e.tag, drv);
    end
    if (e.chk) begin
      n_cmp++;
      assert (t_state === e.t) else begin
        n_err++;
        $error("FAIL %s t_state got %b exp %b", e.tag, t_state, e.t);
      end
      n_cmp++;
      assert (halt === e.h) else begin
        n_err++;
        $error("FAIL %s halt got %b exp %b", e.tag, halt, e.h);
      end
      n_cmp++;
      assert ($onehot(t_state)) else begin
        n_err++;
        $error("FAIL %s onehot got %b exp one-hot", e.tag, t_state);
      end
    end
  endtask
  task automatic step(input logic r, input logic [3:0] op, input string tag, input bit chk);
    sb_t e;
    @(posedge clk);
    #1;
    rst = r;
    opcode = op;
    e.tag = tag;
    e.chk = chk;
    e.t = '0;
    e.t[mt] = 1'b1;
    e.h = mh;
    e.cw = (r || mh) ? 12'h000 : model_cw(mt, op);
    sb.push_back(e);
    @(negedge clk);
    check();
    if (r) begin
      mt = 0;
      mh = 1'b0;
    end else if (!mh) begin
      if (mt == 3 && op == 4'hF) mh = 1'b1;
      else mt = (mt + 1) % 6;
    end
  endtask
  task automatic instr(input logic [3:0] op, input string tag);
    for (int k = 0; k < 6; k++)
      step(1'b0, k < 3 ? 4'($urandom_range(0, 15)) : op, tag, 1'b1);
  endtask
  initial begin
    step(1'b1, 4'h0, "rst_first", 1'b0);
    step(1'b1, 4'h0, "rst_state", 1'b1);
    for (int k = 0; k < 7; k++) step(1'b0, 4'h0, "lda_free", 1'b1);
    step(1'b1, 4'h0, "rst_align", 1'b1);
    instr(4'h1, "add");
    instr(4'h2, "sub");
    instr(4'hE, "out");
    instr(4'h7, "nop");
    instr(4'h0, "lda");
    for (int k = 0; k < 3; k++) step(1'b0, 4'($urandom_range(0, 15)), "hlt_fetch", 1'b1);
    step(1'b0, 4'hF, "hlt_t4", 1'b1);
    for (int k = 0; k < 20; k++) step(1'b0, 4'($urandom_range(0, 15)), "halted", 1'b1);
    step(1'b1, 4'hF, "rst_halt", 1'b1);
    instr(4'h0, "post_halt");
    for (int k = 0; k < 3; k++) step(1'b0, 4'h1, "add_fetch", 1'b1);
    step(1'b0, 4'h1, "add_t4", 1'b1);
    step(1'b1, 4'h1, "rst_t5", 1'b1);
    n_cmp++;
    assert (a_load === 1'b0) else begin
      n_err++;
      $error("FAIL rst_t5_aload got %b exp 0", a_load);
    end
    for (int k = 0; k < 6; k++) step(1'b0, 4'h1, "after_rst", 1'b1);
    for (int k = 0; k < 200; k++) step(1'b0, 4'($urandom_range(0, 14)), "rand", 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
